dmem_bridge: RTL

- Sits directly downstream of the single-cycle mips core, on its data-memory side.
- Accepts the core's per-cycle load/store request (memwrite/memread, aluout address, writedata) and returns readdata.
- Converts it to a multi-cycle req/ack external memory bus.
- Stores are posted through a small write buffer; loads stall the core until the buffer drains and the read completes.

---
 rtl/dmem_bridge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: single-cycle MIPS core load/store port to a multi-cycle req/ack bus.
// Stores are posted through a small circular write buffer; loads stall until it drains and the read returns.
module dmem_bridge #(
  parameter int WBUF_DEPTH = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [AW-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DW-1:0] wb_data_q [WBUF_DEPTH];

  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] readdata_q;
  logic          misalign_q;

  logic [AW-1:0] word_addr;
  logic          full;
  logic          push;
  logic          pop;
  logic          rd_only;
  logic          read_issue;
  logic [PW-1:0] rd_ptr_inc;
  logic [PW-1:0] head_idx;
  logic          head_from_fifo;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  always_comb begin
    word_addr  = {aluout[AW-1:2], 2'b00};
    full       = (count_q == FULL_CNT);
    push       = memwrite & ~full;
    rd_only    = memread & ~memwrite;
    pop        = (state_q == WR_BUS) & mem_ack;
    read_issue = (state_q == IDLE) & (count_q == '0) & rd_only;
    stall      = (memwrite & full) | (rd_only & (state_q != RD_DONE));

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Next entry to put on the bus: either a stored entry, or the store being
    // pushed right now when the buffer would otherwise be empty (bypass).
    rd_ptr_inc = rd_ptr_q + PW'(1);
    if (state_q == WR_BUS) begin
      head_idx       = rd_ptr_inc;
      head_from_fifo = (count_q > CW'(1));
    end else begin
      head_idx       = rd_ptr_q;
      head_from_fifo = (count_q != '0);
    end
    head_addr = head_from_fifo ? wb_addr_q[head_idx] : word_addr;
    head_data = head_from_fifo ? wb_data_q[head_idx] : writedata;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= word_addr;
      wb_data_q[wr_ptr_q] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      readdata_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      misalign_q <= (aluout[1:0] != 2'b00) & (push | read_issue);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_inc;
      end

      case (state_q)
        IDLE: begin
          // Pending writes always win, so a load never overtakes a posted store.
          if (count_q != '0 || push) begin
            state_q     <= WR_BUS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
          end else if (rd_only) begin
            state_q    <= RD_BUS;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= word_addr;
          end
        end
        WR_BUS: begin
          if (mem_ack) begin
            if (count_d != '0) begin
              mem_addr_q  <= head_addr;
              mem_wdata_q <= head_data;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
            end
          end
        end
        RD_BUS: begin
          if (mem_ack) begin
            readdata_q <= mem_rdata;
            mem_req_q  <= 1'b0;
            state_q    <= RD_DONE;
          end
        end
        RD_DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign readdata  = readdata_q;
  assign misalign  = misalign_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
